// File: rtl/poly_pointwise_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : poly_pointwise_ctrl
// Function : Sequencer for NTT-domain pointwise multiply, c[k] = a[k]*b[k] mod Q.
//            Optional accumulate mode, c[k] = (c_old[k] + a[k]*b[k]) mod Q,
//            is enabled by defining POLY_PW_ACC_EN.
// Revision : 1.0 - initial release
// ============================================================================

module poly_pointwise_ctrl_modmul #(
    parameter int Q      = 8380417,
    parameter int DATA_W = 24
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_p
);
    localparam logic [2*DATA_W-1:0] c_q = (2*DATA_W)'(Q);

    logic [2*DATA_W-1:0] w_full;

    assign w_full = i_a * i_b;
    assign o_p    = DATA_W'(w_full % c_q);
endmodule

module poly_pointwise_ctrl #(
    parameter int Q      = 8380417,
    parameter int N      = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
`ifdef POLY_PW_ACC_EN
    input  logic              acc_i,
    input  logic [DATA_W-1:0] c_rdata_i,
`endif
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] a_rdata_i,
    input  logic [DATA_W-1:0] b_rdata_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter is one bit wider than the address so N = 2**ADDR_W is reachable.
    localparam logic [ADDR_W:0] c_n = (ADDR_W+1)'(N);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic                w_issue;
    logic                w_pipe_empty;

    logic                r_p0_vld;
    logic [ADDR_W-1:0]   r_p0_addr;
    logic                r_s1_vld;
    logic [ADDR_W-1:0]   r_s1_addr;
    logic [DATA_W-1:0]   r_s1_a;
    logic [DATA_W-1:0]   r_s1_b;
    logic [DATA_W-1:0]   w_prod;

    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    assign w_issue   = (r_state == S_RUN) && (r_cnt < c_n) && !stall_i;
    assign rd_en_o   = w_issue;
    assign rd_addr_o = r_cnt[ADDR_W-1:0];
    assign busy_o    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done_o    = (r_state == S_DONE);
    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && start_i) begin
                r_cnt <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i)       w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_n)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pipe_empty)  w_state_nxt = S_DONE;
            S_DONE:                     w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Memory data for a read issued in cycle t is valid in t+1 and lands in stage 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p0_vld  <= 1'b0;
            r_p0_addr <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
        end else begin
            r_p0_vld <= w_issue;
            if (w_issue) begin
                r_p0_addr <= rd_addr_o;
            end
            r_s1_vld <= r_p0_vld;
            if (r_p0_vld) begin
                r_s1_addr <= r_p0_addr;
                r_s1_a    <= a_rdata_i;
                r_s1_b    <= b_rdata_i;
            end
        end
    end

    poly_pointwise_ctrl_modmul #(
        .Q      (Q),
        .DATA_W (DATA_W)
    ) u_modmul (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_p (w_prod)
    );

`ifdef POLY_PW_ACC_EN
    localparam logic [DATA_W:0] c_q_ext = (DATA_W+1)'(Q);

    logic                r_acc;
    logic [DATA_W-1:0]   r_s1_c;
    logic                r_s2_vld;
    logic [ADDR_W-1:0]   r_s2_addr;
    logic [DATA_W-1:0]   r_s2_prod;
    logic [DATA_W-1:0]   r_s2_c;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_sum_red;

    assign w_pipe_empty = !r_p0_vld && !r_s1_vld && !r_s2_vld;

    // Both operands are below Q, so a single conditional subtract fully reduces.
    assign w_sum     = {1'b0, r_s2_c} + {1'b0, r_s2_prod};
    assign w_sum_red = (w_sum >= c_q_ext) ? DATA_W'(w_sum - c_q_ext) : DATA_W'(w_sum);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc     <= 1'b0;
            r_s1_c    <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_prod <= '0;
            r_s2_c    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if ((r_state == S_IDLE) && start_i) begin
                r_acc <= acc_i;
            end
            if (r_p0_vld) begin
                r_s1_c <= r_acc ? c_rdata_i : '0;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_addr <= r_s1_addr;
                r_s2_prod <= w_prod;
                r_s2_c    <= r_s1_c;
            end
            r_wr_en <= r_s2_vld;
            if (r_s2_vld) begin
                r_wr_addr <= r_s2_addr;
                r_wr_data <= w_sum_red;
            end
        end
    end
`else
    assign w_pipe_empty = !r_p0_vld && !r_s1_vld;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= r_s1_vld;
            if (r_s1_vld) begin
                r_wr_addr <= r_s1_addr;
                r_wr_data <= w_prod;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_poly_pointwise_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_pointwise_ctrl
// Function : Scoreboard bench for poly_pointwise_ctrl (plain and POLY_PW_ACC_EN builds).
// Revision : 1.0 - initial release
// ============================================================================

module tb_poly_pointwise_ctrl;
    localparam int Q      = 8380417;
    localparam int N      = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 24;
`ifdef POLY_PW_ACC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stall;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
`ifdef POLY_PW_ACC_EN
    logic              acc;
    logic [DATA_W-1:0] c_rdata;
`endif

    int   mem_a [N];
    int   mem_b [N];
    int   mem_c [N];
    exp_t sbq [$];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int runs_started = 0;
    int aborts = 0;
    int run_deadline = 0;
    int exp_done_cyc = -1;
    int busy_t0 = 0;
    int busy_end = 0;
    bit chk_busy = 1'b0;
    bit expect_idle = 1'b0;

    poly_pointwise_ctrl #(
        .Q      (Q),
        .N      (N),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .stall_i   (stall),
`ifdef POLY_PW_ACC_EN
        .acc_i     (acc),
        .c_rdata_i (c_rdata),
`endif
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .a_rdata_i (a_rdata),
        .b_rdata_i (b_rdata),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .busy_o    (busy),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read coefficient memories
    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= DATA_W'(mem_a[rd_addr]);
            b_rdata <= DATA_W'(mem_b[rd_addr]);
`ifdef POLY_PW_ACC_EN
            c_rdata <= DATA_W'(mem_c[rd_addr]);
`endif
        end
    end

    function automatic int golden(input int a, input int b, input int c, input bit use_acc);
        longint p;
        p = (longint'(a) * longint'(b)) % longint'(Q);
        if (use_acc) p = (p + longint'(c)) % longint'(Q);
        return int'(p);
    endfunction

    // Monitor: pops the scoreboard on every write and checks handshake outputs
    always @(negedge clk) begin : mon
        exp_t e;
        int   pending;
        pending = runs_started - aborts - done_cnt;
        if (rst) begin
            n_vec++;
            if (rd_en || rd_addr != '0 || wr_en || wr_addr != '0 || wr_data != '0 || busy || done) begin
                n_err++;
                $display("FAIL reset_outputs: got rd_en=%b rd_addr=%0d wr_en=%b wr_addr=%0d wr_data=%0d busy=%b done=%b, required all 0",
                         rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done);
            end
        end else begin
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write @%0d: got addr=%0d data=%0d, required no write", cyc, wr_addr, wr_data);
                end else begin
                    e = sbq.pop_front();
                    n_vec++;
                    if (int'(wr_addr) != e.addr) begin
                        n_err++;
                        $display("FAIL wr_addr @%0d: got %0d, required %0d", cyc, wr_addr, e.addr);
                    end
                    n_vec++;
                    if (int'(wr_data) != e.data) begin
                        n_err++;
                        $display("FAIL wr_data addr=%0d: got %0d, required %0d", e.addr, wr_data, e.data);
                    end
                    if (e.cyc >= 0) begin
                        n_vec++;
                        if (cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL wr_cycle addr=%0d: got %0d, required %0d", e.addr, cyc, e.cyc);
                        end
                    end
                end
            end
            if (done) begin
                n_vec++;
                if (pending <= 0) begin
                    n_err++;
                    $display("FAIL unexpected_done @%0d: got done=1, required 0", cyc);
                end else begin
                    if (exp_done_cyc >= 0) begin
                        n_vec++;
                        if (cyc != exp_done_cyc) begin
                            n_err++;
                            $display("FAIL done_cycle: got %0d, required %0d", cyc, exp_done_cyc);
                        end
                    end
                    if (sbq.size() != 0) begin
                        n_err++;
                        $display("FAIL done_pending: got %0d writes outstanding, required 0", sbq.size());
                    end
                    done_cnt++;
                end
            end else if (pending > 0 && cyc > run_deadline) begin
                n_vec++;
                n_err++;
                $display("FAIL run_timeout @%0d: got no done, required done by %0d", cyc, run_deadline);
                done_cnt++;
            end
            if (chk_busy && cyc >= busy_t0 && cyc <= busy_end + 1) begin
                n_vec++;
                if (busy != (cyc > busy_t0 && cyc <= busy_end)) begin
                    n_err++;
                    $display("FAIL busy @%0d: got %b, required %b", cyc, busy, (cyc > busy_t0 && cyc <= busy_end));
                end
            end
            if (expect_idle) begin
                n_vec++;
                if (busy || rd_en || done || wr_en) begin
                    n_err++;
                    $display("FAIL idle @%0d: got busy=%b rd_en=%b done=%b wr_en=%b, required all 0", cyc, busy, rd_en, done, wr_en);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random; 1: directed multiply vectors; 2: directed accumulate vectors
    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = int'($urandom_range(Q - 1));
            mem_b[i] = int'($urandom_range(Q - 1));
            mem_c[i] = int'($urandom_range(Q - 1));
        end
        if (mode == 1) begin
            mem_a[0] = 2;       mem_b[0] = 3;
            mem_a[1] = 4194304; mem_b[1] = 2;
            mem_a[2] = Q - 1;   mem_b[2] = Q - 1;
            mem_a[3] = 0;       mem_b[3] = 5;
        end else if (mode == 2) begin
            mem_a[0] = 1;     mem_b[0] = 1;
            mem_c[0] = Q - 1; mem_c[1] = Q - 1;
            mem_c[2] = Q - 1; mem_c[3] = Q - 1;
        end
    endtask

    task automatic idle_cycles(input int n);
        expect_idle = 1'b1;
        repeat (n) tick();
    endtask

    // stall_mode 0: none; 1: stall in cycles 2-3 of the run; 2: random
    task automatic do_run(input int stall_mode, input bit hold_start, input bit use_acc, input int rst_at);
        int   t0;
        int   rel;
        exp_t e;
        sbq.delete();
        expect_idle = 1'b0;
        t0 = cyc;
        start = 1'b1;
`ifdef POLY_PW_ACC_EN
        acc = use_acc;
`endif
        for (int k = 0; k < N; k++) begin
            e.addr = k;
            e.data = golden(mem_a[k], mem_b[k], mem_c[k], use_acc);
            if (stall_mode == 0)      e.cyc = t0 + LAT + k;
            else if (stall_mode == 1) e.cyc = t0 + LAT + k + ((k > 0) ? 2 : 0);
            else                      e.cyc = -1;
            sbq.push_back(e);
        end
        exp_done_cyc = (stall_mode == 2) ? -1 : t0 + N + LAT + ((stall_mode == 1) ? 2 : 0);
        busy_t0      = t0;
        busy_end     = exp_done_cyc - 1;
        chk_busy     = (stall_mode != 2);
        run_deadline = t0 + 3 * N + 50;
        runs_started++;
        tick();
        while ((runs_started - aborts - done_cnt) > 0 && cyc <= run_deadline + 2) begin
            rel = cyc - t0;
            if (stall_mode == 1)      stall = (rel == 2 || rel == 3);
            else if (stall_mode == 2) stall = ($urandom_range(3) == 0);
            else                      stall = 1'b0;
            start = hold_start || (rel == 3);
            if (rst_at > 0 && rel == rst_at) begin
                #2;
                rst = 1'b1;
                tick();
                tick();
                start = 1'b0;
                stall = 1'b0;
                sbq.delete();
                chk_busy = 1'b0;
                aborts++;
                rst = 1'b0;
                break;
            end
            tick();
        end
        start = 1'b0;
        stall = 1'b0;
        chk_busy = 1'b0;
        idle_cycles(4);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
`ifdef POLY_PW_ACC_EN
        acc   = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        idle_cycles(3);

        fill(1);
        do_run(0, 1'b0, 1'b0, 0);
        do_run(1, 1'b0, 1'b0, 0);

        fill(0);
        do_run(0, 1'b1, 1'b0, 0);
        idle_cycles(6);

        fill(0);
        do_run(0, 1'b0, 1'b0, 3);
        idle_cycles(20);
        do_run(0, 1'b0, 1'b0, 0);

`ifdef POLY_PW_ACC_EN
        fill(2);
        do_run(0, 1'b0, 1'b1, 0);
        fill(0);
        do_run(1, 1'b0, 1'b1, 0);
`endif

        for (int r = 0; r < 4; r++) begin
            fill(0);
`ifdef POLY_PW_ACC_EN
            do_run(2, 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
`else
            do_run(2, 1'($urandom_range(1)), 1'b0, 0);
`endif
        end

        idle_cycles(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
